snake_line_scheduler: RTL and testbench

- Per-scanline controller that builds the 40-bit row bitmap (`line_vram`) for the snake playfield.
- On each line request from the VGA side it sequences reads of the snake node RAM (x/y per body node) and accumulates the matching nodes plus the apple into a row buffer.
- It then hands the finished row to the VGA scan logic with a one-cycle valid strobe.
- It replaces free-running node indexing with a bounded, length-aware scan.

---
 rtl/snake_line_if.sv | 45 ++++
 rtl/snake_line_scheduler.sv | 156 +++++++++++++++
 tb/tb_snake_line_scheduler.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/snake_line_if.sv
// snake_line_if: the VGA-side line request/response bundle for snake_line_scheduler.
//
//   master (VGA scan side):
//     line_req, y_pos, snake_len, apple_x, apple_y  -> request
//     line_vram, line_valid, busy, req_drop          <- response
//   slave (scheduler side): same signals, opposite directions.
//
// Optional: when SNAKE_SELF_HIT_EN is defined, the bundle carries self_hit
// (scheduler -> VGA side).
interface snake_line_if #(
   parameter int unsigned GRID_W  = 40,
   parameter int unsigned COORD_W = 6,
   parameter int unsigned NODE_AW = 4
);
   logic               line_req;
   logic [COORD_W-1:0] y_pos;
   logic [NODE_AW:0]   snake_len;
   logic [COORD_W-1:0] apple_x;
   logic [COORD_W-1:0] apple_y;
   logic [GRID_W-1:0]  line_vram;
   logic               line_valid;
   logic               busy;
   logic               req_drop;
`ifdef SNAKE_SELF_HIT_EN
   logic               self_hit;

   modport master (
      output line_req, y_pos, snake_len, apple_x, apple_y,
      input  line_vram, line_valid, busy, req_drop, self_hit
   );
   modport slave (
      input  line_req, y_pos, snake_len, apple_x, apple_y,
      output line_vram, line_valid, busy, req_drop, self_hit
   );
`else
   modport master (
      output line_req, y_pos, snake_len, apple_x, apple_y,
      input  line_vram, line_valid, busy, req_drop
   );
   modport slave (
      input  line_req, y_pos, snake_len, apple_x, apple_y,
      output line_vram, line_valid, busy, req_drop
   );
`endif
endinterface

// File: rtl/snake_line_scheduler.sv
// snake_line_scheduler: builds one GRID_W-bit row bitmap of the snake
// playfield per line request. On an accepted request it scans the first
// min(snake_len, MAX_NODES) entries of the node RAM (2-cycle read latency),
// ORs every node lying on the requested row plus the apple into an
// accumulator, then publishes the row with a one-cycle line_valid strobe.
//
// Ports:
//   clk_50MHz  in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   line       slave of snake_line_if: line_req/y_pos/snake_len/apple_x/
//              apple_y in; line_vram/line_valid/busy/req_drop out
//   node_addr  out  node RAM read address (registered)
//   node_x     in   node RAM x data, valid 2 cycles after node_addr
//   node_y     in   node RAM y data, same timing
//
// Optional feature macro: SNAKE_SELF_HIT_EN -- adds line.self_hit, a pulse in
// the line_valid cycle when a body node (index >= 1) on the scanned row sits
// on the head cell.
module snake_line_scheduler #(
   parameter int unsigned GRID_W    = 40,
   parameter int unsigned COORD_W   = 6,
   parameter int unsigned NODE_AW   = 4,
   parameter int unsigned MAX_NODES = 16
) (
   input  logic               clk_50MHz,
   input  logic               rst,
   snake_line_if.slave        line,
   output logic [NODE_AW-1:0] node_addr,
   input  logic [COORD_W-1:0] node_x,
   input  logic [COORD_W-1:0] node_y
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [NODE_AW:0] MAX_N = MAX_NODES[NODE_AW:0];

   state_t             state, next_state;
   logic [COORD_W-1:0] y_lat;
   logic [NODE_AW:0]   n_lat;
   logic [NODE_AW:0]   n_eff;
   logic [GRID_W-1:0]  acc, acc_next;
   logic [GRID_W-1:0]  apple_bits;
   logic               rd_v1, rd_v2;
   logic               accept;
   logic               last_addr;
   logic               node_hit_row;

   // One-hot column mask; columns >= GRID_W yield all zeros.
   function automatic logic [GRID_W-1:0] cell_bit(input logic [COORD_W-1:0] x);
      logic [GRID_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < GRID_W; i++) begin
         if (32'(x) == i) r[i] = 1'b1;
      end
      return r;
   endfunction

   assign accept       = (state == IDLE) && line.line_req;
   assign n_eff        = (line.snake_len > MAX_N) ? MAX_N : line.snake_len;
   assign last_addr    = ({1'b0, node_addr} == (n_lat - 1'b1));
   assign apple_bits   = (line.apple_y == line.y_pos) ? cell_bit(line.apple_x) : '0;
   assign node_hit_row = rd_v2 && (node_y == y_lat);
   assign line.busy    = (state != IDLE);

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (line.line_req) next_state = (n_eff == '0) ? DONE : ISSUE;
         ISSUE:   if (last_addr) next_state = DRAIN;
         // rd_v2 is consumed in this same cycle, so only rd_v1 must be empty.
         DRAIN:   if (!rd_v1) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      acc_next = acc;
      if (accept) begin
         acc_next = apple_bits;
      end else if (node_hit_row) begin
         acc_next = acc | cell_bit(node_x);
      end
   end

   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         state           <= IDLE;
         y_lat           <= '0;
         n_lat           <= '0;
         acc             <= '0;
         rd_v1           <= 1'b0;
         rd_v2           <= 1'b0;
         node_addr       <= '0;
         line.line_vram  <= '0;
         line.line_valid <= 1'b0;
         line.req_drop   <= 1'b0;
      end else begin
         state           <= next_state;
         acc             <= acc_next;
         rd_v1           <= (state == ISSUE);
         rd_v2           <= rd_v1;
         line.req_drop   <= line.line_req && (state != IDLE);
         // Row is published on the edge entering DONE so that line_vram is
         // already current during the line_valid cycle.
         line.line_valid <= (next_state == DONE);
         if (next_state == DONE) line.line_vram <= acc_next;
         if (accept) begin
            y_lat     <= line.y_pos;
            n_lat     <= n_eff;
            node_addr <= '0;
         end else if ((state == ISSUE) && !last_addr) begin
            node_addr <= node_addr + 1'b1;
         end
      end
   end

`ifdef SNAKE_SELF_HIT_EN
   logic [NODE_AW-1:0] ret_idx;
   logic [COORD_W-1:0] head_x, head_y;
   logic               hit, hit_next;

   always_comb begin
      hit_next = hit;
      if (accept) begin
         hit_next = 1'b0;
      end else if (node_hit_row && (ret_idx != '0) &&
                   (node_x == head_x) && (node_y == head_y)) begin
         hit_next = 1'b1;
      end
   end

   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         ret_idx       <= '0;
         head_x        <= '0;
         head_y        <= '0;
         hit           <= 1'b0;
         line.self_hit <= 1'b0;
      end else begin
         hit           <= hit_next;
         line.self_hit <= (next_state == DONE) && hit_next;
         if (accept) begin
            ret_idx <= '0;
         end else if (rd_v2) begin
            ret_idx <= ret_idx + 1'b1;
            if (ret_idx == '0) begin
               head_x <= node_x;
               head_y <= node_y;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_snake_line_scheduler.sv
module tb_snake_line_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] node_addr;
   logic [5:0] node_x, node_y;
   logic [3:0] a_q;
   int         cyc = 0;

   int mx [16];
   int my [16];

   snake_line_if #(.GRID_W(40), .COORD_W(6), .NODE_AW(4)) bus ();

   snake_line_scheduler #(.GRID_W(40), .COORD_W(6), .NODE_AW(4), .MAX_NODES(16)) dut (
      .clk_50MHz (clk),
      .rst       (rst),
      .line      (bus.slave),
      .node_addr (node_addr),
      .node_x    (node_x),
      .node_y    (node_y)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Node RAM: address register then output register -> 2-cycle latency.
   always @(posedge clk) begin
      a_q    <= node_addr;
      node_x <= 6'(mx[a_q]);
      node_y <= 6'(my[a_q]);
   end

   typedef struct {
      logic [39:0] vram;
      int          cyc;
      logic [15:0] amask;
      logic        hit;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_drop_cyc = -1;
   logic [15:0] seen = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: row bitmap from the node list and apple.
   function automatic logic [39:0] ref_row(input int y, input int len, input int ax, input int ay);
      logic [39:0] r;
      int n;
      n = (len > 16) ? 16 : len;
      r = '0;
      if (ay == y && ax < 40) r[ax] = 1'b1;
      for (int i = 0; i < n; i++)
         if (my[i] == y && mx[i] < 40) r[mx[i]] = 1'b1;
      return r;
   endfunction

   function automatic logic ref_hit(input int y, input int len);
      int n;
      n = (len > 16) ? 16 : len;
      for (int i = 1; i < n; i++)
         if (mx[i] == mx[0] && my[i] == my[0] && my[i] == y) return 1'b1;
      return 1'b0;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a row.
   always @(negedge clk) begin
      if (rst) begin
         seen = '0;
      end else begin
         if (bus.busy === 1'b1) seen = seen | (16'd1 << node_addr);
         if (bus.req_drop === 1'b1 || cyc == exp_drop_cyc)
            chk("req_drop", {63'd0, bus.req_drop}, {63'd0, (cyc == exp_drop_cyc)});
         if (bus.line_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", {63'd0, bus.line_valid}, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("line_vram", {24'd0, bus.line_vram}, {24'd0, e.vram});
               chk("latency", 64'(cyc), 64'(e.cyc));
               chk("addr_set", {48'd0, seen}, {48'd0, e.amask});
`ifdef SNAKE_SELF_HIT_EN
               chk("self_hit", {63'd0, bus.self_hit}, {63'd0, e.hit});
`endif
            end
            seen = '0;
         end
      end
   end

   task automatic wait_idle();
      int t;
      t = 0;
      while (bus.busy !== 1'b0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (bus.busy !== 1'b0) chk("idle_wait", {63'd0, bus.busy}, 64'd0);
   endtask

   task automatic do_req(input int y, input int len, input int ax, input int ay, input bit push);
      exp_t e;
      int n;
      wait_idle();
      n = (len > 16) ? 16 : len;
      bus.line_req  = 1'b1;
      bus.y_pos     = 6'(y);
      bus.snake_len = 5'(len);
      bus.apple_x   = 6'(ax);
      bus.apple_y   = 6'(ay);
      if (push) begin
         e.vram  = ref_row(y, len, ax, ay);
         e.cyc   = cyc + ((n == 0) ? 1 : n + 3);
         e.amask = (n == 0) ? 16'd1 : 16'((32'd1 << n) - 1);
         e.hit   = ref_hit(y, len);
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      bus.line_req = 1'b0;
   endtask

   task automatic set_node(input int i, input int x, input int y);
      mx[i] = x;
      my[i] = y;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, y, ax, ay;
      for (int i = 0; i < 16; i++) begin mx[i] = 63; my[i] = 63; end
      bus.line_req  = 1'b0;
      bus.y_pos     = '0;
      bus.snake_len = '0;
      bus.apple_x   = '0;
      bus.apple_y   = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_line_vram", {24'd0, bus.line_vram}, 64'd0);
      chk("rst_line_valid", {63'd0, bus.line_valid}, 64'd0);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_req_drop", {63'd0, bus.req_drop}, 64'd0);
      chk("rst_node_addr", {60'd0, node_addr}, 64'd0);
`ifdef SNAKE_SELF_HIT_EN
      chk("rst_self_hit", {63'd0, bus.self_hit}, 64'd0);
`endif

      // Empty snake: apple only, then apple out of range.
      do_req(7, 0, 39, 7, 1);
      do_req(7, 0, 45, 7, 1);

      // Over-length snake clamps to 16; a request mid-scan is dropped.
      for (int i = 0; i < 16; i++) set_node(i, i * 2, (i % 3 == 0) ? 9 : 4);
      do_req(9, 20, 1, 9, 1);
      repeat (3) @(posedge clk);
      #1;
      bus.line_req = 1'b1;
      bus.y_pos    = 6'd4;
      exp_drop_cyc = cyc + 1;
      @(posedge clk); #1;
      bus.line_req = 1'b0;

      // Basic three-node row.
      wait_idle();
      set_node(0, 10, 5); set_node(1, 11, 5); set_node(2, 11, 6);
      do_req(5, 3, 20, 5, 1);

      // Reset while issuing aborts the scan and clears the row.
      wait_idle();
      do_req(5, 5, 20, 5, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", {63'd0, bus.busy}, 64'd0);
      chk("abort_line_vram", {24'd0, bus.line_vram}, 64'd0);
      chk("abort_line_valid", {63'd0, bus.line_valid}, 64'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Head collision on the scanned row, then same body off-row.
      set_node(0, 4, 2); set_node(1, 5, 2); set_node(2, 4, 2);
      do_req(2, 3, 30, 0, 1);
      do_req(3, 3, 30, 0, 1);

      // Randomized rows.
      for (int k = 0; k < 40; k++) begin
         wait_idle();
         for (int i = 0; i < 16; i++) begin
            if (i > 0 && $urandom_range(0, 5) == 0) set_node(i, mx[0], my[0]);
            else set_node(i, int'($urandom_range(0, 47)), int'($urandom_range(0, 5)));
         end
         len = int'($urandom_range(0, 20));
         y   = int'($urandom_range(0, 5));
         ax  = int'($urandom_range(0, 63));
         ay  = int'($urandom_range(0, 5));
         do_req(y, len, ax, ay, 1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      begin
         int t;
         t = 0;
         while ((exp_q.size() != 0 || bus.busy !== 1'b0) && t < 200) begin
            @(posedge clk); #1;
            t++;
         end
         chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      end
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
